// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard event path: decoder states,
// prefix/error byte constants and the packed key-event layout.
package keyboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_state_e;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  // Identity of a key for the repeat filter: make and break share this key.
  function automatic logic [8:0] evt_key(input kbd_evt_t e);
    return {e.ext, e.code};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit
// so full/empty are told apart without a separate counter.
module event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_s  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign dout_o    = mem_q[rptr_q[AW-1:0]];
  assign count_o   = wptr_q - rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/keyboard_event_reader.sv
// Pops PS/2 bytes from the receiver FIFO, folds E0/F0 prefixes into complete
// key events, optionally filters typematic repeats and buffers the events.
module keyboard_event_reader
  import keyboard_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int FILTER_REPEAT = 1,
  parameter int DROP_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ps2_data,
  input  logic                     ps2_ready,
  output logic                     ps2_nextdata,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_brk,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  dec_state_e        state_q, state_d;
  logic              nextdata_q;
  logic              held_vld_q, held_vld_d;
  logic [8:0]        held_key_q, held_key_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              accept_s;
  logic              raw_vld_s;
  kbd_evt_t          raw_evt_s;
  logic              emit_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  kbd_evt_t          head_s;

  assign accept_s   = ps2_ready & ~nextdata_q;
  assign fifo_pop_s = evt_valid & evt_ready;

  // Prefix decoder and repeat filter.
  always_comb begin
    state_d    = state_q;
    held_vld_d = held_vld_q;
    held_key_d = held_key_q;
    raw_vld_s  = 1'b0;
    raw_evt_s  = '0;
    emit_s     = 1'b0;
    if (accept_s) begin
      case (ps2_data)
        BYTE_E0: state_d = ST_E0;
        BYTE_F0: begin
          case (state_q)
            ST_IDLE: state_d = ST_F0;
            ST_E0:   state_d = ST_E0F0;
            default: state_d = state_q;
          endcase
        end
        BYTE_00, BYTE_FF: state_d = ST_IDLE;
        default: begin
          raw_vld_s      = 1'b1;
          raw_evt_s.ext  = (state_q == ST_E0) || (state_q == ST_E0F0);
          raw_evt_s.brk  = (state_q == ST_F0) || (state_q == ST_E0F0);
          raw_evt_s.code = ps2_data;
          state_d        = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Filter state follows every emitted event, whether or not the FIFO takes it.
    if (raw_vld_s) begin
      if (raw_evt_s.brk) begin
        emit_s = 1'b1;
        if (held_vld_q && (held_key_q == evt_key(raw_evt_s))) begin
          held_vld_d = 1'b0;
        end else begin
          held_vld_d = held_vld_q;
        end
      end else if ((FILTER_REPEAT != 0) && held_vld_q && (held_key_q == evt_key(raw_evt_s))) begin
        emit_s = 1'b0;
      end else begin
        emit_s     = 1'b1;
        held_vld_d = 1'b1;
        held_key_d = evt_key(raw_evt_s);
      end
    end else begin
      emit_s = 1'b0;
    end
  end

  // Saturating count of events lost to a full FIFO.
  always_comb begin
    drop_d = drop_q;
    if (emit_s && fifo_full_s && !fifo_pop_s && (drop_q != '1)) begin
      drop_d = drop_q + DROP_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // Decoder, filter, drop counter and pop-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      nextdata_q <= 1'b0;
      held_vld_q <= 1'b0;
      held_key_q <= 9'h000;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      nextdata_q <= accept_s;
      held_vld_q <= held_vld_d;
      held_key_q <= held_key_d;
      drop_q     <= drop_d;
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (emit_s),
    .din_i   (raw_evt_s),
    .pop_i   (fifo_pop_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (evt_count)
  );

  assign ps2_nextdata = nextdata_q;
  assign evt_valid    = ~fifo_empty_s;
  assign evt_code     = head_s.code;
  assign evt_ext      = head_s.ext;
  assign evt_brk      = head_s.brk;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_keyboard_event_reader.sv
// Directed bench: instance a (DEPTH=4, filter on) covers decoding, overflow and
// reset; instance b (DEPTH=8, filter off) shares the byte stream for repeats.
module tb_keyboard_event_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       evt_ready_a = 1'b0;
  logic       evt_ready_b = 1'b0;

  logic       nd_a, valid_a, ext_a, brk_a;
  logic [7:0] code_a, drop_a;
  logic [2:0] count_a;
  logic       nd_b, valid_b, ext_b, brk_b;
  logic [7:0] code_b, drop_b;
  logic [3:0] count_b;

  int checks = 0;
  int errors = 0;
  int nd_pulses = 0;
  bit nd_prev = 1'b0;
  bit nd_double = 1'b0;

  keyboard_event_reader #(.DEPTH(4), .FILTER_REPEAT(1), .DROP_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_nextdata(nd_a), .evt_valid(valid_a), .evt_ready(evt_ready_a),
    .evt_code(code_a), .evt_ext(ext_a), .evt_brk(brk_a),
    .evt_count(count_a), .drop_cnt(drop_a)
  );

  keyboard_event_reader #(.DEPTH(8), .FILTER_REPEAT(0), .DROP_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_nextdata(nd_b), .evt_valid(valid_b), .evt_ready(evt_ready_b),
    .evt_code(code_b), .evt_ext(ext_b), .evt_brk(brk_b),
    .evt_count(count_b), .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  // Pop-pulse monitor: counts pulses and flags any pulse longer than one cycle.
  always @(negedge clk) begin
    if (nd_a) nd_pulses++;
    if (nd_a && nd_prev) nd_double = 1'b1;
    nd_prev = nd_a;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ps2_ready = 1'b0;
    evt_ready_a = 1'b0;
    evt_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one byte; it is taken at the next edge, then the bus idles a cycle.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_data = b;
    ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
  endtask

  task automatic pop_a();
    @(negedge clk);
    evt_ready_a = 1'b1;
    @(negedge clk);
    evt_ready_a = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({nd_a, valid_a, count_a, drop_a, ext_a, brk_a, code_a} !== 23'h0) begin
      errors++;
      $display("FAIL reset_state: got nd=%0b v=%0b cnt=%0d drop=%0d evt=%0b%0b%h, want all 0",
               nd_a, valid_a, count_a, drop_a, ext_a, brk_a, code_a);
    end
  endtask

  task automatic test_make_break();
    int p0;
    do_reset();
    p0 = nd_pulses;
    send_byte(8'h1C);
    checks++;
    if (valid_a !== 1'b1 || {ext_a, brk_a, code_a} !== 10'h01C) begin
      errors++;
      $display("FAIL make_latency: got v=%0b evt=%0b%0b%h, want v=1 evt=0 0 1c", valid_a, ext_a, brk_a, code_a);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    @(negedge clk);
    checks++;
    if (nd_pulses - p0 !== 3 || nd_double !== 1'b0) begin
      errors++;
      $display("FAIL nextdata_pulses: got %0d pulses double=%0b, want 3 double=0", nd_pulses - p0, nd_double);
    end
    checks++;
    if (count_a !== 3'd2) begin
      errors++;
      $display("FAIL make_break_count: got %0d, want 2", count_a);
    end
    pop_a();
    checks++;
    if ({ext_a, brk_a, code_a} !== 10'h11C) begin
      errors++;
      $display("FAIL break_event: got %0b%0b%h, want 0 1 1c", ext_a, brk_a, code_a);
    end
    pop_a();
    checks++;
    if (valid_a !== 1'b0 || count_a !== 3'd0) begin
      errors++;
      $display("FAIL drained: got v=%0b cnt=%0d, want 0 0", valid_a, count_a);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++;
    if (count_a !== 3'd2 || {ext_a, brk_a, code_a} !== 10'h275) begin
      errors++;
      $display("FAIL ext_make: got cnt=%0d evt=%0b%0b%h, want 2 1 0 75", count_a, ext_a, brk_a, code_a);
    end
    pop_a();
    checks++;
    if ({ext_a, brk_a, code_a} !== 10'h375) begin
      errors++;
      $display("FAIL ext_break: got %0b%0b%h, want 1 1 75", ext_a, brk_a, code_a);
    end
    pop_a();
    // Error bytes cancel a pending prefix and produce nothing.
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'hFF); send_byte(8'h1D);
    checks++;
    if (count_a !== 3'd2 || {ext_a, brk_a, code_a} !== 10'h01C) begin
      errors++;
      $display("FAIL err_byte_1: got cnt=%0d evt=%0b%0b%h, want 2 0 0 1c", count_a, ext_a, brk_a, code_a);
    end
    pop_a();
    checks++;
    if ({ext_a, brk_a, code_a} !== 10'h01D) begin
      errors++;
      $display("FAIL err_byte_2: got %0b%0b%h, want 0 0 1d", ext_a, brk_a, code_a);
    end
  endtask

  task automatic test_repeat_filter();
    do_reset();
    repeat (4) send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    checks++;
    if (count_a !== 3'd2) begin
      errors++;
      $display("FAIL filter_on_count: got %0d, want 2", count_a);
    end
    checks++;
    if (count_b !== 4'd5) begin
      errors++;
      $display("FAIL filter_off_count: got %0d, want 5", count_b);
    end
    send_byte(8'h1C);
    checks++;
    if (count_a !== 3'd3 || drop_a !== 8'd0) begin
      errors++;
      $display("FAIL make_after_release: got cnt=%0d drop=%0d, want 3 0", count_a, drop_a);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [6];
    logic [7:0] expect_q [4];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    expect_q = '{8'h1D, 8'h24, 8'h2D, 8'h3C};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(codes[i]);
    checks++;
    if (count_a !== 3'd4 || drop_a !== 8'd2 || code_a !== 8'h15) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d drop=%0d head=%h, want 4 2 15", count_a, drop_a, code_a);
    end
    // Push and pop on the same edge while full.
    @(negedge clk);
    ps2_data = 8'h3C;
    ps2_ready = 1'b1;
    evt_ready_a = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
    evt_ready_a = 1'b0;
    checks++;
    if (count_a !== 3'd4 || drop_a !== 8'd2) begin
      errors++;
      $display("FAIL full_push_pop: got cnt=%0d drop=%0d, want 4 2", count_a, drop_a);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_a !== 1'b1 || code_a !== expect_q[i]) begin
        errors++;
        $display("FAIL fifo_order_%0d: got v=%0b code=%h, want 1 %h", i, valid_a, code_a, expect_q[i]);
      end
      pop_a();
    end
    checks++;
    if (valid_a !== 1'b0) begin
      errors++;
      $display("FAIL fifo_empty_after: got v=%0b, want 0", valid_a);
    end
  endtask

  task automatic test_reset_mid_sequence();
    send_byte(8'h44);
    send_byte(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    checks++;
    if (valid_a !== 1'b0 || drop_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_flush: got v=%0b drop=%0d, want 0 0", valid_a, drop_a);
    end
    send_byte(8'h75);
    checks++;
    if (count_a !== 3'd1 || {ext_a, brk_a, code_a} !== 10'h075 || drop_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_prefix: got cnt=%0d evt=%0b%0b%h drop=%0d, want 1 0 0 75 0",
               count_a, ext_a, brk_a, code_a, drop_a);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_repeat_filter();
    test_overflow();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
